// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 decryptor.
// S-boxes are computed from the field inverse plus affine map rather than stored as tables.
package aes_dec_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, base;
    r    = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
            gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
            gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
            gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
  endfunction

  // byte index 4*col+row sits at bits [127-8*idx -: 8]; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] forward_next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inverse_prev_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_dec_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_dec_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] s,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] s_next
);

  logic [127:0] shifted, subbed, keyed, mixed;

  always_comb begin
    subbed  = '0;
    mixed   = '0;
    shifted = inv_shift_rows(s);
    for (int i = 0; i < 16; i++) subbed[8*i +: 8] = inv_sbox(shifted[8*i +: 8]);
    keyed = subbed ^ round_key;
    for (int c = 0; c < 4; c++) mixed[32*c +: 32] = inv_mix_column(keyed[32*c +: 32]);
    s_next = last_round ? keyed : mixed;
  end

endmodule

// File: rtl/aes_128_dec.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then 10 inverse rounds.
// Optional AES_DEC_KEY_CACHE_EN remembers the last key/K10 pair to skip expansion.
module aes_128_dec
  import aes_dec_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] rk, s, ct_reg;
  logic [127:0] rk_fwd, rk_prev, s_next;
  logic         cache_hit;
  logic [127:0] hit_k10;

  assign rk_fwd  = forward_next_key(rk, RCON[cnt]);
  assign rk_prev = inverse_prev_key(rk, RCON[cnt]);

  aes_dec_round u_round (
    .s         (s),
    .round_key (rk_prev),
    .last_round(cnt == 4'd0),
    .s_next    (s_next)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] key_reg, cached_key, cached_k10;
  logic         cache_valid;

  assign cache_hit = cache_valid && (key == cached_key);
  assign hit_k10   = cached_k10;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg     <= '0;
      cached_key  <= '0;
      cached_k10  <= '0;
      cache_valid <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      key_reg <= key;
    end else if (state == KEXP && cnt == LAST_CNT) begin
      cached_key  <= key_reg;
      cached_k10  <= rk_fwd;
      cache_valid <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_k10   = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rk        <= '0;
      s         <= '0;
      ct_reg    <= '0;
      pt        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          ct_reg   <= ct;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (cache_hit) begin
            rk    <= hit_k10;
            s     <= ct ^ hit_k10;
            cnt   <= LAST_CNT;
            state <= DEC;
          end else begin
            rk    <= key;
            cnt   <= '0;
            state <= KEXP;
          end
        end
        KEXP: begin
          rk <= rk_fwd;
          if (cnt == LAST_CNT) begin
            s     <= ct_reg ^ rk_fwd;
            state <= DEC;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DEC: begin
          s  <= s_next;
          rk <= rk_prev;
          if (cnt == 4'd0) begin
            pt        <= s_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_dec.sv
// Self-checking bench for aes_128_dec: byte-array AES inverse cipher model plus
// a handshake/latency model compared against the DUT every cycle.
module tb_aes_128_dec;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ct = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] pt;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes_128_dec #(.NR(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ct       (ct),
    .key      (key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pt       (pt),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference cipher ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x = x << 1;
      if (hi) x = x ^ 8'h1b;
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ ((q << 1) | (q >> 7)) ^ ((q << 2) | (q >> 6)) ^ ((q << 3) | (q >> 5)) ^ ((q << 4) | (q >> 4));
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] c);
    logic [7:0] ks [176];
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] t [4];
    logic [7:0] rc, tt, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) ks[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = ks[i-4+j];
      if (i % 16 == 0) begin
        tt = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[tt];
        rc = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) ks[i+j] = ks[i-16+j] ^ t[j];
    end
    for (int i = 0; i < 16; i++) st[i] = c[127-8*i -: 8] ^ ks[160+i];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int col = 0; col < 4; col++)
        for (int r = 0; r < 4; r++)
          tmp[r+4*col] = st[r+4*((col-r+4)%4)];
      for (int i = 0; i < 16; i++) st[i] = isb[tmp[i]] ^ ks[16*rnd+i];
      if (rnd > 0) begin
        for (int col = 0; col < 4; col++) begin
          a0 = st[4*col]; a1 = st[4*col+1]; a2 = st[4*col+2]; a3 = st[4*col+3];
          st[4*col]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
          st[4*col+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
          st[4*col+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
          st[4*col+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // ---------------- handshake / latency model ----------------
  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;
  int           m_phase = M_IDLE;
  int           m_remain = 0;
  logic [127:0] m_exp_pt = '0;
  logic [127:0] m_pending_pt = '0;
  bit           m_cache_valid = 1'b0;
  logic [127:0] m_cached_key = '0;

  function automatic int lat_for(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
    return (m_cache_valid && k == m_cached_key) ? 10 : 20;
`else
    return (k === k) ? 20 : 20;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = M_IDLE;
      m_exp_pt = '0;
      m_cache_valid = 1'b0;
    end else begin
      case (m_phase)
        M_IDLE: if (in_valid) begin
          m_remain = lat_for(key);
          m_pending_pt = model_decrypt(key, ct);
          m_cache_valid = 1'b1;
          m_cached_key = key;
          m_phase = M_BUSY;
        end
        M_BUSY: begin
          m_remain--;
          if (m_remain == 0) begin
            m_phase = M_DONE;
            m_exp_pt = m_pending_pt;
          end
        end
        default: if (out_ready) m_phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_phase == M_IDLE);
    check("busy", busy, m_phase == M_BUSY);
    check("out_valid", out_valid, m_phase == M_DONE);
    check("pt", pt, m_exp_pt);
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_job(input logic [127:0] k, input logic [127:0] c, input int hold,
                         input bit use_lit, input logic [127:0] lit_pt);
    int n, exp_lat;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_wait", in_ready, 1'b1);
    exp_lat = lat_for(k);
    key = k; ct = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    key = rnd128();
    ct = rnd128();
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("latency", n, exp_lat);
    if (use_lit) check("pt_literal", pt, lit_pt);
    repeat (hold) @(negedge clk);
    check("pt_held", pt, model_decrypt(k, c));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_rise", in_ready, 1'b1);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    build_tables();
    check("model_sbox_53", sb[8'h53], 8'hed);
    check("model_isbox_63", isb[8'h63], 8'h00);
    check("model_v1", model_decrypt(K1, C1), P1);
    check("model_v2", model_decrypt(K2, C2), P2);
    check("model_v3", model_decrypt('0, C3), '0);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pt", pt, '0);

    run_job(K1, C1, 0, 1'b1, P1);
    run_job(K2, C2, 2, 1'b1, P2);
    run_job('0, C3, 7, 1'b1, '0);

    // abort mid-decrypt: accept, then reset five cycles into the inverse rounds
    key = K2; ct = C2; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_dec_busy", busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_pt", pt, '0);
    run_job(K2, C2, 1, 1'b1, P2);

    for (int i = 0; i < 6; i++) run_job(rnd128(), rnd128(), $urandom_range(0, 3), 1'b0, '0);

    run_job(K1, C1, 0, 1'b1, P1);
    run_job(K1, rnd128(), 1, 1'b0, '0);
    run_job('0, C3, 0, 1'b1, '0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
